// File: rtl/gecko_print_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gecko_print_uart: buffers the core's print byte stream and sends 8N1 UART. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module gecko_print_uart #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            print_in_valid,
  output logic                            print_in_ready,
  input  logic [7:0]                      print_in_payload,
  output logic                            uart_tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] c_baud_max = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("gecko_print_uart: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("gecko_print_uart: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic w_push;
  logic w_pop;
  logic w_nempty;

  assign w_nempty = (r_count != '0);
  assign print_in_ready = (r_count < c_depth);
  assign w_push = print_in_valid && print_in_ready;
  // The FSM only ever takes a byte from IDLE or at the end of a stop bit.
  assign w_pop = w_nempty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && (r_baud == '0)));

  assign uart_tx    = r_tx;
  assign busy       = (r_state != S_IDLE) || w_nempty;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= print_in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_baud  <= c_baud_max;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_baud == '0) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_baud    <= c_baud_max;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == '0) begin
            r_baud <= c_baud_max;
            if (r_bit_idx != 3'd7) begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == '0) begin
            if (w_pop) begin
              // Next start bit follows the stop bit directly, no idle gap.
              r_shift <= r_mem[r_rd_ptr];
              r_tx    <= 1'b0;
              r_baud  <= c_baud_max;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gecko_print_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gecko_print_uart: directed bench for gecko_print_uart (10 clks/bit).    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_gecko_print_uart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pv  = 1'b0;
  logic       pr;
  logic [7:0] pd  = 8'h00;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic       mon_en = 1'b0;
  logic [7:0] rx_byte;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int         w;
  int         lows;

  gecko_print_uart #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .print_in_valid  (pv),
    .print_in_ready  (pr),
    .print_in_payload(pd),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the edge that accepted byte b into an idle UART.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k <= 10) return 1'b0;
    if (k <= 90) return b[(k - 11) / 10];
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] b, input int maxw, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    pv     = 1'b1;
    pd     = b;
    forever begin
      acc = pr;
      tick();
      waited++;
      if (acc) break;
      if (waited >= maxw) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    if (acc) expq.push_back(b);
    pv = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    repeat (5) tick();
    chk({tag, "_nbytes"}, rxq.size(), expq.size());
    while (expq.size() > 0 && rxq.size() > 0) chk({tag, "_byte"}, rxq.pop_front(), expq.pop_front());
    expq.delete();
    rxq.delete();
  endtask

  // Serial decoder: samples each bit mid-period, starting from the first low cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          rx_byte[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        chk("stop_bit", uart_tx, 1);
        rxq.push_back(rx_byte);
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", pr, 1);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Single byte, exact waveform
    push_byte(8'h41, 5, w);
    chk("t1_tx0", uart_tx, 1);
    chk("t1_cnt", fifo_count, 1);
    chk("t1_busy", busy, 1);
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (k <= 100) chk("t1_tx", uart_tx, exp_tx(8'h41, k));
      if (k == 100) chk("t1_busy_stop", busy, 1);
      if (k == 101) chk("t1_busy_end", busy, 0);
    end
    drain_check("t1");

    // Back-to-back frames
    push_byte(8'h55, 5, w);
    push_byte(8'hAA, 5, w);
    chk("t2_cnt1", fifo_count, 1);
    chk("t2_tx1", uart_tx, exp_tx(8'h55, 1));
    for (int k = 2; k <= 200; k++) begin
      tick();
      chk("t2_tx", uart_tx, (k <= 100) ? exp_tx(8'h55, k) : exp_tx(8'hAA, k - 100));
      if (k == 100) chk("t2_cnt_pre", fifo_count, 1);
      if (k == 101) chk("t2_cnt0", fifo_count, 0);
    end
    drain_check("t2");

    // Full FIFO backpressure
    for (int b = 1; b <= 5; b++) push_byte(8'(b), 5, w);
    chk("t3_full_cnt", fifo_count, 4);
    chk("t3_full_ready", pr, 0);
    push_byte(8'h06, 300, w);
    chk("t3_wait6", w, 98);
    chk("t3_cnt6", fifo_count, 4);
    chk("t3_ready6", pr, 0);
    push_byte(8'h07, 300, w);
    chk("t3_wait7", w, 100);
    drain_check("t3");

    // Push on the same edge the STOP expiry pops the head
    push_byte(8'h11, 5, w);
    repeat (4) tick();
    push_byte(8'h22, 5, w);
    repeat (95) tick();
    chk("t4_cnt_pre", fifo_count, 1);
    chk("t4_tx_stop", uart_tx, 1);
    push_byte(8'h33, 5, w);
    chk("t4_cnt_post", fifo_count, 1);
    chk("t4_tx_start", uart_tx, 0);
    drain_check("t4");

    // Reset during data bit 3 of 0xF0 with two bytes queued
    mon_en = 1'b0;
    push_byte(8'hF0, 5, w);
    push_byte(8'h12, 5, w);
    push_byte(8'h34, 5, w);
    chk("t5_cnt_q", fifo_count, 2);
    repeat (42) tick();
    chk("t5_bit3", uart_tx, 0);
    rst = 1'b1;
    tick();
    chk("t5_tx", uart_tx, 1);
    chk("t5_cnt", fifo_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", pr, 1);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("t5_quiet", lows, 0);
    expq.delete();
    rxq.delete();
    mon_en = 1'b1;

    // Pointer wrap with random bytes and gaps
    for (int i = 0; i < 13; i++) begin
      push_byte(8'($urandom), 300, w);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain_check("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
